// File: rtl/eth_gt_reset_ctrl.sv
// rtl/eth_gt_reset_ctrl.sv - per-lane transceiver reset sequencing and link recovery
// Each lane independently walks HOLD -> WAIT_DONE -> WAIT_LOCK -> UP and retries on timeout or lock loss.
module eth_gt_reset_ctrl #(
  parameter int LANES           = 1,
  parameter int HOLD_CYCLES     = 1024,
  parameter int DONE_TIMEOUT    = 1048576,
  parameter int LOCK_TIMEOUT    = 1048576,
  parameter int RX_RESET_CYCLES = 16,
  parameter int LOSS_CYCLES     = 256,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 clock_ok,
  input  logic                 clear_counts,
  input  logic [LANES-1:0]     gt_tx_done,
  input  logic [LANES-1:0]     gt_rx_done,
  input  logic [LANES-1:0]     rx_block_lock,
  output logic [LANES-1:0]     gt_reset_all,
  output logic [LANES-1:0]     gt_reset_rx_datapath,
  output logic [LANES-1:0]     link_up,
  output logic [3*LANES-1:0]   lane_state,
  output logic [8*LANES-1:0]   retry_count
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TMAX = max2(max2(max2(HOLD_CYCLES, DONE_TIMEOUT), max2(LOCK_TIMEOUT, RX_RESET_CYCLES)),
                             LOSS_CYCLES);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] DONE_LAST = TW'(DONE_TIMEOUT - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] RX_LAST   = TW'(RX_RESET_CYCLES - 1);
  localparam logic [TW-1:0] LOSS_LAST = TW'(LOSS_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_DONE = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_RX_RESET  = 3'd3,
    ST_UP        = 3'd4
  } state_e;

  logic [SYNC_STAGES-1:0] ok_sync_q;
  logic [LANES-1:0]       tx_sync_q   [SYNC_STAGES];
  logic [LANES-1:0]       rx_sync_q   [SYNC_STAGES];
  logic [LANES-1:0]       lock_sync_q [SYNC_STAGES];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ok_sync_q <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        tx_sync_q[s]   <= '0;
        rx_sync_q[s]   <= '0;
        lock_sync_q[s] <= '0;
      end
    end else begin
      ok_sync_q      <= {ok_sync_q[SYNC_STAGES-2:0], clock_ok};
      tx_sync_q[0]   <= gt_tx_done;
      rx_sync_q[0]   <= gt_rx_done;
      lock_sync_q[0] <= rx_block_lock;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        tx_sync_q[s]   <= tx_sync_q[s-1];
        rx_sync_q[s]   <= rx_sync_q[s-1];
        lock_sync_q[s] <= lock_sync_q[s-1];
      end
    end
  end

  logic             ok_s;
  logic [LANES-1:0] done_s;
  logic [LANES-1:0] lock_s;

  assign ok_s   = ok_sync_q[SYNC_STAGES-1];
  assign done_s = tx_sync_q[SYNC_STAGES-1] & rx_sync_q[SYNC_STAGES-1];
  assign lock_s = lock_sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    retry_q, retry_d;
    logic          bump;
    logic          reset_all_q, rx_reset_q, up_q;

    always_comb begin
      state_d = state_q;
      bump    = 1'b0;
      if (!ok_s) begin
        state_d = ST_HOLD;
      end else begin
        case (state_q)
          ST_HOLD: begin
            if (timer_q == HOLD_LAST) state_d = ST_WAIT_DONE;
          end
          ST_WAIT_DONE: begin
            if (done_s[i]) begin
              state_d = ST_WAIT_LOCK;
            end else if (timer_q == DONE_LAST) begin
              state_d = ST_HOLD;
              bump    = 1'b1;
            end
          end
          ST_WAIT_LOCK: begin
            if (!done_s[i]) begin
              state_d = ST_WAIT_DONE;
            end else if (lock_s[i]) begin
              state_d = ST_UP;
            end else if (timer_q == LOCK_LAST) begin
              state_d = ST_RX_RESET;
              bump    = 1'b1;
            end
          end
          ST_RX_RESET: begin
            if (timer_q == RX_LAST) state_d = ST_WAIT_DONE;
          end
          ST_UP: begin
            if (!done_s[i]) begin
              state_d = ST_WAIT_DONE;
            end else if (!lock_s[i] && (timer_q == LOSS_LAST)) begin
              state_d = ST_WAIT_LOCK;
            end
          end
          default: state_d = ST_HOLD;
        endcase
      end

      // In UP the timer measures the current run of consecutive lock-low cycles.
      if (!ok_s || (state_d != state_q)) begin
        timer_d = '0;
      end else if ((state_q == ST_UP) && lock_s[i]) begin
        timer_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end

      if (clear_counts) begin
        retry_d = 8'd0;
      end else if (bump && (retry_q != 8'hFF)) begin
        retry_d = retry_q + 8'd1;
      end else begin
        retry_d = retry_q;
      end
    end

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        state_q     <= ST_HOLD;
        timer_q     <= '0;
        retry_q     <= 8'd0;
        reset_all_q <= 1'b1;
        rx_reset_q  <= 1'b0;
        up_q        <= 1'b0;
      end else begin
        state_q     <= state_d;
        timer_q     <= timer_d;
        retry_q     <= retry_d;
        reset_all_q <= (state_d == ST_HOLD);
        rx_reset_q  <= (state_d == ST_RX_RESET);
        up_q        <= (state_d == ST_UP);
      end
    end

    assign gt_reset_all[i]         = reset_all_q;
    assign gt_reset_rx_datapath[i] = rx_reset_q;
    assign link_up[i]              = up_q;
    assign lane_state[3*i +: 3]    = state_q;
    assign retry_count[8*i +: 8]   = retry_q;
  end

endmodule

// File: tb/tb_eth_gt_reset_ctrl.sv
// tb/tb_eth_gt_reset_ctrl.sv - randomized and directed bench for eth_gt_reset_ctrl
// A cycle-level reference model tracks time-in-state per lane; outputs are compared every cycle.
module tb_eth_gt_reset_ctrl;

  localparam int LANES           = 2;
  localparam int HOLD_CYCLES     = 8;
  localparam int DONE_TIMEOUT    = 32;
  localparam int LOCK_TIMEOUT    = 64;
  localparam int RX_RESET_CYCLES = 4;
  localparam int LOSS_CYCLES     = 8;
  localparam int S               = 2;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             clock_ok = 1'b1;
  logic             clear_counts = 1'b0;
  logic [LANES-1:0] gt_tx_done = '0;
  logic [LANES-1:0] gt_rx_done = '0;
  logic [LANES-1:0] rx_block_lock = '0;
  logic [LANES-1:0] gt_reset_all;
  logic [LANES-1:0] gt_reset_rx_datapath;
  logic [LANES-1:0] link_up;
  logic [3*LANES-1:0] lane_state;
  logic [8*LANES-1:0] retry_count;

  eth_gt_reset_ctrl #(
    .LANES(LANES), .HOLD_CYCLES(HOLD_CYCLES), .DONE_TIMEOUT(DONE_TIMEOUT),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .RX_RESET_CYCLES(RX_RESET_CYCLES),
    .LOSS_CYCLES(LOSS_CYCLES), .SYNC_STAGES(S)
  ) dut (
    .clock(clock), .resetn(resetn), .clock_ok(clock_ok), .clear_counts(clear_counts),
    .gt_tx_done(gt_tx_done), .gt_rx_done(gt_rx_done), .rx_block_lock(rx_block_lock),
    .gt_reset_all(gt_reset_all), .gt_reset_rx_datapath(gt_reset_rx_datapath),
    .link_up(link_up), .lane_state(lane_state), .retry_count(retry_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane=%0d actual=%0d expected=%0d", name, lane, act, exp);
    end
  endtask

  // Reference model: state code, cycles spent in state, lock-low run, retries.
  int m_st    [LANES] = '{default: 0};
  int m_t     [LANES] = '{default: 0};
  int m_low   [LANES] = '{default: 0};
  int m_retry [LANES] = '{default: 0};
  logic       h_ok [S] = '{default: 1'b0};
  logic [1:0] h_tx [S] = '{default: 2'b00};
  logic [1:0] h_rx [S] = '{default: 2'b00};
  logic [1:0] h_lk [S] = '{default: 2'b00};
  logic       s_ok;
  logic [1:0] s_tx, s_rx, s_lk;

  task automatic lane_step(input int i, input logic ok, input logic done, input logic lock, input logic clr);
    int nxt;
    bit bump;
    nxt  = m_st[i];
    bump = 0;
    if (!ok) nxt = 0;
    else case (m_st[i])
      0: if (m_t[i] + 1 >= HOLD_CYCLES) nxt = 1;
      1: if (done) nxt = 2;
         else if (m_t[i] + 1 >= DONE_TIMEOUT) begin nxt = 0; bump = 1; end
      2: if (!done) nxt = 1;
         else if (lock) nxt = 4;
         else if (m_t[i] + 1 >= LOCK_TIMEOUT) begin nxt = 3; bump = 1; end
      3: if (m_t[i] + 1 >= RX_RESET_CYCLES) nxt = 1;
      4: if (!done) nxt = 1;
         else if (!lock && (m_low[i] + 1 >= LOSS_CYCLES)) nxt = 2;
      default: nxt = 0;
    endcase
    if (nxt != m_st[i] || !ok) begin
      m_t[i]   = 0;
      m_low[i] = 0;
    end else begin
      m_t[i]++;
      m_low[i] = lock ? 0 : m_low[i] + 1;
    end
    if (clr) m_retry[i] = 0;
    else if (bump && m_retry[i] < 255) m_retry[i]++;
    m_st[i] = nxt;
  endtask

  initial begin : model
    forever begin
      @(posedge clock or negedge resetn);
      if (!resetn) begin
        for (int i = 0; i < LANES; i++) begin
          m_st[i] = 0; m_t[i] = 0; m_low[i] = 0; m_retry[i] = 0;
        end
        for (int s = 0; s < S; s++) begin
          h_ok[s] = 1'b0; h_tx[s] = '0; h_rx[s] = '0; h_lk[s] = '0;
        end
      end else begin
        s_ok = h_ok[S-1]; s_tx = h_tx[S-1]; s_rx = h_rx[S-1]; s_lk = h_lk[S-1];
        for (int s = S - 1; s > 0; s--) begin
          h_ok[s] = h_ok[s-1]; h_tx[s] = h_tx[s-1]; h_rx[s] = h_rx[s-1]; h_lk[s] = h_lk[s-1];
        end
        h_ok[0] = clock_ok; h_tx[0] = gt_tx_done; h_rx[0] = gt_rx_done; h_lk[0] = rx_block_lock;
        for (int i = 0; i < LANES; i++)
          lane_step(i, s_ok, s_tx[i] & s_rx[i], s_lk[i], clear_counts);
      end
    end
  end

  always @(negedge clock) begin
    for (int i = 0; i < LANES; i++) begin
      chk("lane_state", i, lane_state[3*i +: 3], m_st[i]);
      chk("gt_reset_all", i, gt_reset_all[i], m_st[i] == 0);
      chk("gt_reset_rx_datapath", i, gt_reset_rx_datapath[i], m_st[i] == 3);
      chk("link_up", i, link_up[i], m_st[i] == 4);
      chk("retry_count", i, retry_count[8*i +: 8], m_retry[i]);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  int seq[$];
  int exp_seq[4] = '{0, 1, 2, 4};

  task automatic step_rec();
    step(1);
    if (lane_state[2:0] != seq[$]) seq.push_back(int'(lane_state[2:0]));
  endtask

  int n, cnt, c, bad, r, to, prev;

  initial begin
    seq.push_back(0);
    step(3);
    chk("reset_state", -1, lane_state, 0);
    chk("reset_all_in_reset", -1, gt_reset_all, 2'b11);

    // Power-up
    resetn = 1'b1;
    n = 0;
    do begin step_rec(); n++; end while (gt_reset_all[0] && n < 100);
    chk("powerup_release_cycles", 0, n, 10);
    repeat (5) step_rec();
    gt_tx_done = 2'b11; gt_rx_done = 2'b11; rx_block_lock = 2'b11;
    repeat (10) step_rec();
    chk("powerup_seq_len", 0, seq.size(), 4);
    for (int k = 0; k < seq.size() && k < 4; k++) chk("powerup_seq", k, seq[k], exp_seq[k]);
    chk("powerup_state", -1, lane_state, 6'o44);
    chk("powerup_link_up", -1, link_up, 2'b11);
    chk("powerup_retry", -1, retry_count, 0);

    // Done timeout on lane 1
    gt_tx_done[1] = 1'b0;
    n = 0; cnt = 0;
    while (!(lane_state[5:3] == 0 && retry_count[15:8] == 1) && n < 200) begin
      step(1); n++;
      if (lane_state[5:3] == 1) cnt++;
    end
    chk("done_timeout_cycles", 1, cnt, 32);
    chk("done_timeout_retry1", 1, retry_count[15:8], 1);
    n = 0;
    while (retry_count[15:8] != 3 && n < 300) begin step(1); n++; end
    chk("done_timeout_retry3", 1, retry_count[15:8], 3);
    chk("lane0_still_up", 0, lane_state[2:0], 4);
    chk("lane0_retry", 0, retry_count[7:0], 0);

    // Lock timeout on lane 1
    gt_tx_done[1] = 1'b1; rx_block_lock[1] = 1'b0;
    step(14);
    clear_counts = 1'b1; step(1); clear_counts = 1'b0;
    chk("clear_retry", 1, retry_count[15:8], 0);
    n = 0;
    while (lane_state[5:3] != 3 && n < 200) begin step(1); n++; end
    chk("lock_timeout_retry", 1, retry_count[15:8], 1);
    c = 0; n = 0;
    while (lane_state[5:3] == 3 && n < 20) begin
      if (gt_reset_rx_datapath[1]) c++;
      step(1); n++;
    end
    chk("rx_pulse_width", 1, c, 4);
    chk("after_rx_wait_done", 1, lane_state[5:3], 1);
    cnt = 0; n = 0;
    while (lane_state[5:3] != 3 && n < 200) begin
      step(1); n++;
      if (lane_state[5:3] == 2) cnt++;
    end
    chk("wait_lock_cycles", 1, cnt, 64);

    // Lock-loss debounce
    rx_block_lock[1] = 1'b1;
    n = 0;
    while (lane_state[5:3] != 4 && n < 200) begin step(1); n++; end
    chk("reach_up", 1, lane_state[5:3], 4);
    step(4);
    r = retry_count[15:8];
    rx_block_lock[1] = 1'b0; bad = 0;
    repeat (7) begin step(1); if (lane_state[5:3] != 4) bad++; end
    rx_block_lock[1] = 1'b1;
    repeat (10) begin step(1); if (lane_state[5:3] != 4) bad++; end
    chk("loss7_stays_up", 1, bad, 0);
    rx_block_lock[1] = 1'b0;
    step(9);
    chk("loss8_boundary_up", 1, lane_state[5:3], 4);
    step(1);
    chk("loss8_wait_lock", 1, lane_state[5:3], 2);
    chk("loss8_link_down", 1, link_up[1], 0);
    chk("loss8_retry_same", 1, retry_count[15:8], r);

    // clock_ok drop in the middle of an RX-datapath pulse
    n = 0;
    while (lane_state[5:3] != 3 && n < 300) begin step(1); n++; end
    chk("rx_reached", 1, lane_state[5:3], 3);
    clock_ok = 1'b0;
    step(2);
    chk("rx_before_abort", 1, lane_state[5:3], 3);
    step(1);
    chk("drop_state_hold", -1, lane_state, 0);
    chk("drop_reset_all", -1, gt_reset_all, 2'b11);
    chk("drop_rx_aborted", -1, gt_reset_rx_datapath, 0);
    chk("drop_link_down", -1, link_up, 0);
    clock_ok = 1'b1; rx_block_lock[1] = 1'b1;

    // Saturation: 300 done timeouts on lane 1
    gt_tx_done[1] = 1'b0;
    to = 0; n = 0; prev = int'(lane_state[5:3]);
    while (to < 300 && n < 14000) begin
      step(1); n++;
      if (prev == 1 && lane_state[5:3] == 0) to++;
      prev = int'(lane_state[5:3]);
    end
    chk("timeouts_seen", 1, to, 300);
    chk("retry_saturated", 1, retry_count[15:8], 255);

    // clear_counts on the same edge as an increment
    n = 0;
    while (!(m_st[1] == 1 && m_t[1] == DONE_TIMEOUT - 1) && n < 100) begin step(1); n++; end
    chk("clear_align_found", 1, n < 100, 1);
    clear_counts = 1'b1; step(1); clear_counts = 1'b0;
    chk("clear_beats_increment", 1, retry_count[15:8], 0);
    chk("clear_increment_state", 1, lane_state[5:3], 0);

    // Randomized traffic with one asynchronous reset mid-run
    for (int k = 0; k < 3000; k++) begin
      step(1);
      for (int i = 0; i < LANES; i++) begin
        if ($urandom_range(0, 99) < 2) gt_tx_done[i] = ~gt_tx_done[i];
        if ($urandom_range(0, 99) < 2) gt_rx_done[i] = ~gt_rx_done[i];
        if ($urandom_range(0, 99) < 5) rx_block_lock[i] = ~rx_block_lock[i];
      end
      if (clock_ok && $urandom_range(0, 399) == 0) clock_ok = 1'b0;
      else if (!clock_ok && $urandom_range(0, 9) == 0) clock_ok = 1'b1;
      clear_counts = ($urandom_range(0, 199) == 0);
      if (k == 1500) begin
        resetn = 1'b0;
        step(2);
        resetn = 1'b1;
      end
    end
    clear_counts = 1'b0;
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
